// File: rtl/avalon_fir_round_saturate_if.sv
// Avalon-ST streaming bundle: data, valid and a 2-bit error sideband.
// The producer drives through the master modport and the consumer reads through slave.
interface avalon_fir_round_saturate_if #(
    parameter int W = 12
);
    logic [W-1:0] data;
    logic         valid;
    logic [1:0]   error;

    modport master (output data, valid, error);
    modport slave  (input  data, valid, error);
endinterface

// File: rtl/avalon_fir_round_saturate.sv
// Reduces a wide signed FIR sample to 12-bit Avalon-ST.
// Datapath: variable arithmetic right shift, optional round-half-up, then saturation.
// Clipped samples raise error bit 0, and a sticky 16-bit counter tallies them.
// Register stages:
//   - acceptance register
//   - shift/round register
//   - saturated output register
// Each sample appears two edges after the edge that accepts it.
module avalon_fir_round_saturate #(
    parameter int IN_W      = 24,
    parameter int OUT_W     = 12,
    parameter int SHIFT_W   = 4,
    parameter int MAX_SHIFT = 12,
    parameter int ROUND     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SHIFT_W-1:0]  shift,
    input  logic                sat_clear,
    avalon_fir_round_saturate_if.slave  sink,
    avalon_fir_round_saturate_if.master source,
    output logic [15:0]         sat_count
);
    localparam int SW     = IN_W + 1;  // one guard bit so the rounding add cannot wrap
    localparam int STAGES = 2;
    localparam logic signed [SW-1:0] Q_MAX = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] Q_MIN = SW'(-(2 ** (OUT_W - 1)));

    // vld_pipe[0]: accepted, [1]: shifted, [2]: on the source bus
    logic [STAGES:0]        vld_pipe;
    logic [IN_W-1:0]        in_data;
    logic [SHIFT_W-1:0]     in_shift;
    logic [1:0]             in_err;

    logic [SHIFT_W-1:0]     s_eff;
    logic signed [SW-1:0]   rnd;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   q;
    logic signed [SW-1:0]   q_r;
    logic [1:0]             q_err;

    logic                   sat_hi;
    logic                   sat_lo;
    logic [OUT_W-1:0]       sat_data;
    logic                   sat_ev;

    logic [OUT_W-1:0]       out_data;
    logic [1:0]             out_err;

    // Capture the sample together with the shift it arrived with; the shift is frozen for its flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            in_data  <= '0;
            in_shift <= '0;
            in_err   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], sink.valid};
            if (sink.valid) begin
                in_data  <= sink.data;
                in_shift <= shift;
                in_err   <= sink.error;
            end
        end
    end

    // Clamp the shift, add the half-LSB rounding constant, then arithmetic shift in IN_W+1 bits
    always_comb begin
        s_eff = (int'(in_shift) > MAX_SHIFT) ? SHIFT_W'(MAX_SHIFT) : in_shift;
        rnd   = '0;
        if (ROUND != 0 && s_eff != '0)
            rnd = SW'(1) << (s_eff - SHIFT_W'(1));
        sum = $signed({in_data[IN_W-1], in_data}) + rnd;
        q   = sum >>> s_eff;
    end

    // Shifted value register; holds through invalid cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r   <= '0;
            q_err <= '0;
        end else if (vld_pipe[0]) begin
            q_r   <= q;
            q_err <= in_err;
        end
    end

    // Saturate to the OUT_W signed range; an event only counts for a valid sample
    always_comb begin
        sat_hi   = (q_r > Q_MAX);
        sat_lo   = (q_r < Q_MIN);
        sat_data = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                   sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : q_r[OUT_W-1:0];
        sat_ev   = vld_pipe[1] & (sat_hi | sat_lo);
    end

    // Output register; data and error hold their last valid values across gaps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_err  <= '0;
        end else if (vld_pipe[1]) begin
            out_data <= sat_data;
            out_err  <= {q_err[1], q_err[0] | sat_hi | sat_lo};
        end
    end

    // Sticky event counter: a clear wins over accumulation but still counts a coincident event
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_count <= '0;
        else if (sat_clear)
            sat_count <= sat_ev ? 16'd1 : 16'd0;
        else if (sat_ev && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end

    assign source.data  = out_data;
    assign source.valid = vld_pipe[STAGES];
    assign source.error = out_err;

endmodule

// File: tb/tb_avalon_fir_round_saturate.sv
// Self-checking bench.
// Two DUTs share one sink stream: rnd_r uses ROUND=1 and rnd_t uses ROUND=0 (truncate).
// Each is compared against an integer reference model that tracks:
//   - a two-step delay queue
//   - per-DUT expected outputs
//   - per-DUT sticky counts
module tb_avalon_fir_round_saturate;
    logic       clk;
    logic       reset;
    logic [3:0] shift_i;
    logic       clr_i;
    logic [15:0] cnt_r, cnt_t;

    avalon_fir_round_saturate_if #(.W(24)) snk();
    avalon_fir_round_saturate_if #(.W(12)) src_r();
    avalon_fir_round_saturate_if #(.W(12)) src_t();

    avalon_fir_round_saturate #(.ROUND(1)) dut_r (
        .clk(clk), .reset(reset), .shift(shift_i), .sat_clear(clr_i),
        .sink(snk.slave), .source(src_r.master), .sat_count(cnt_r)
    );
    avalon_fir_round_saturate #(.ROUND(0)) dut_t (
        .clk(clk), .reset(reset), .shift(shift_i), .sat_clear(clr_i),
        .sink(snk.slave), .source(src_t.master), .sat_count(cnt_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [23:0] d;
        int          sh;
        logic [1:0]  e;
    } rec_t;

    rec_t        hist[$];
    bit          exp_v[2];
    logic [11:0] exp_d[2];
    logic [1:0]  exp_e[2];
    int          exp_c[2];
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic:
    //   1. clamp the shift
    //   2. optionally add half an LSB
    //   3. floor-divide by a power of two
    //   4. clip to the 12-bit range
    function automatic void ref_calc(input logic [23:0] d, input int sh, input bit rnd,
                                     output logic [11:0] o, output bit sat);
        longint v;
        int s;
        v = longint'($signed(d));
        s = (sh > 12) ? 12 : sh;
        if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        sat = (v > 2047) || (v < -2048);
        if (v > 2047) v = 2047;
        else if (v < -2048) v = -2048;
        o = v[11:0];
    endfunction

    task automatic model_reset();
        rec_t idle;
        idle = '{v: 1'b0, d: '0, sh: 0, e: '0};
        hist.delete();
        hist.push_back(idle);
        hist.push_back(idle);
        for (int r = 0; r < 2; r++) begin
            exp_v[r] = 1'b0; exp_d[r] = '0; exp_e[r] = '0; exp_c[r] = 0;
        end
    endtask

    // One clock: drive inputs, clock, advance the model, compare both DUTs
    task automatic step(input bit v, input logic [23:0] d, input int sh,
                        input logic [1:0] e, input bit clr);
        rec_t cur, old;
        logic [11:0] o;
        bit s, ev;
        snk.valid = v; snk.data = d; snk.error = e;
        shift_i = 4'(sh); clr_i = clr;
        @(posedge clk);
        #1;
        cur = '{v: v, d: d, sh: sh, e: e};
        hist.push_back(cur);
        old = hist.pop_front();
        for (int r = 0; r < 2; r++) begin
            ev = 1'b0;
            if (old.v) begin
                ref_calc(old.d, old.sh, (r == 0), o, s);
                exp_v[r] = 1'b1; exp_d[r] = o; exp_e[r] = {old.e[1], old.e[0] | s};
                ev = s;
            end else begin
                exp_v[r] = 1'b0;
            end
            if (clr) exp_c[r] = ev ? 1 : 0;
            else if (ev && exp_c[r] < 65535) exp_c[r]++;
        end
        if (chk_en) begin
            chk("valid_r", 32'(src_r.valid), 32'(exp_v[0]));
            chk("data_r",  32'(src_r.data),  32'(exp_d[0]));
            chk("err_r",   32'(src_r.error), 32'(exp_e[0]));
            chk("cnt_r",   32'(cnt_r),       32'(exp_c[0]));
            chk("valid_t", 32'(src_t.valid), 32'(exp_v[1]));
            chk("data_t",  32'(src_t.data),  32'(exp_d[1]));
            chk("err_t",   32'(src_t.error), 32'(exp_e[1]));
            chk("cnt_t",   32'(cnt_t),       32'(exp_c[1]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 0, 2'b00, 1'b0);
    endtask

    initial begin
        logic signed [23:0] x;
        reset = 1'b1; clr_i = 1'b0; shift_i = '0;
        snk.valid = 1'b0; snk.data = '0; snk.error = '0;
        #1;
        chk("rst_valid", 32'(src_r.valid), 32'd0);
        chk("rst_data",  32'(src_r.data),  32'd0);
        chk("rst_err",   32'(src_r.error), 32'd0);
        chk("rst_cnt",   32'(cnt_r),       32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        idle(2);

        // Rounding, positive and negative, shift 4
        step(1'b1, 24'h000123, 4, 2'b00, 1'b0);
        idle(2);
        chk("rnd_pos_r", 32'(src_r.data), 32'h012);
        chk("rnd_pos_t", 32'(src_t.data), 32'h012);
        step(1'b1, 24'hFFFEDD, 4, 2'b00, 1'b0);
        idle(2);
        chk("rnd_neg_r", 32'(src_r.data), 32'hFEE);
        chk("rnd_neg_err", 32'(src_r.error), 32'h0);

        // Saturation, back-to-back, shift 0
        step(1'b0, 24'h0, 0, 2'b00, 1'b1);
        step(1'b1, 24'h001388, 0, 2'b10, 1'b0);
        step(1'b1, 24'hFFEC78, 0, 2'b00, 1'b0);
        step(1'b1, 24'h0007FF, 0, 2'b00, 1'b0);
        step(1'b1, 24'hFFF800, 0, 2'b00, 1'b0);
        idle(2);
        chk("sat_cnt2", 32'(cnt_r), 32'd2);

        // Clamped shift with rounding overflow
        step(1'b1, 24'h7FFFFF, 15, 2'b00, 1'b0);
        idle(2);
        chk("clamp_data", 32'(src_r.data), 32'h7FF);
        chk("clamp_cnt",  32'(cnt_r), 32'd3);

        // Alternating valid gaps
        for (int i = 0; i < 8; i++) step(i[0] == 1'b0, 24'($urandom), $urandom_range(0, 15), 2'($urandom), 1'b0);
        idle(2);

        // Random stream: wide magnitude spread, random shift/error/gaps/clears
        for (int i = 0; i < 300; i++) begin
            x = 24'($urandom);
            x = x >>> $urandom_range(0, 22);
            step($urandom_range(0, 3) != 0, x, $urandom_range(0, 15), 2'($urandom),
                 $urandom_range(0, 40) == 0);
        end
        idle(2);

        // Counter saturates at 0xFFFF
        chk_en = 1'b0;
        for (int i = 0; i < 65540; i++) step(1'b1, 24'h001388, 0, 2'b00, 1'b0);
        chk_en = 1'b1;
        idle(2);
        chk("cnt_stick_r", 32'(cnt_r), 32'hFFFF);
        chk("cnt_stick_t", 32'(cnt_t), 32'hFFFF);

        // Clear coincident with a saturating output, then clear alone
        step(1'b1, 24'h001388, 0, 2'b00, 1'b0);
        idle(1);
        step(1'b0, 24'h0, 0, 2'b00, 1'b1);
        chk("clr_ev", 32'(cnt_r), 32'd1);
        step(1'b0, 24'h0, 0, 2'b00, 1'b1);
        chk("clr_only", 32'(cnt_r), 32'd0);

        // Asynchronous reset with two samples in flight
        step(1'b1, 24'h000400, 0, 2'b01, 1'b0);
        step(1'b1, 24'hFFFC00, 0, 2'b01, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(src_r.valid), 32'd0);
        chk("arst_data",  32'(src_r.data),  32'd0);
        chk("arst_err",   32'(src_r.error), 32'd0);
        chk("arst_cnt",   32'(cnt_r),       32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        idle(3);
        step(1'b1, 24'h000123, 4, 2'b00, 1'b0);
        step(1'b0, 24'h0, 0, 2'b00, 1'b0);
        chk("post_rst_early", 32'(src_r.valid), 32'd0);
        step(1'b0, 24'h0, 0, 2'b00, 1'b0);
        chk("post_rst_valid", 32'(src_r.valid), 32'd1);
        chk("post_rst_data",  32'(src_r.data),  32'h012);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
